mem_stage_pipe: RTL and testbench

Parametrised EX/MEM pipeline register plus data-memory access stage with a registered MEM/WB output. It sits between the ALU stage and write-back of the 5-stage MIPS core. Supports byte, halfword and word loads and stores, sign- or zero-extended loads, pipeline stall and flush, and pass-through of non-memory results. Replaces the fixed-function word-only EX/MEM block.

---
 rtl/mem_stage_pipe_if.sv | 30 +++
 rtl/mem_stage_pipe.sv | 93 +++++++++
 tb/tb_mem_stage_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pipe_if.sv
// mem_stage_pipe_if: EX-side inputs and WB-side outputs of the memory stage.
interface mem_stage_pipe_if #(parameter int REG_W = 5);
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [31:0]      alu_result;
    logic [31:0]      store_data;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       mem_size;
    logic             mem_unsigned;
    logic [REG_W-1:0] rd_in;
    logic             reg_write_in;
    logic             out_valid;
    logic [31:0]      wb_data;
    logic [REG_W-1:0] rd_out;
    logic             reg_write_out;
    logic             misalign;
    logic             store_done;
    modport master (
        output in_valid, stall, flush, alu_result, store_data, mem_read, mem_write,
               mem_size, mem_unsigned, rd_in, reg_write_in,
        input  out_valid, wb_data, rd_out, reg_write_out, misalign, store_done
    );
    modport slave (
        input  in_valid, stall, flush, alu_result, store_data, mem_read, mem_write,
               mem_size, mem_unsigned, rd_in, reg_write_in,
        output out_valid, wb_data, rd_out, reg_write_out, misalign, store_done
    );
endinterface

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: EX/MEM register, byte/half/word data memory and MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN flags misaligned half/word accesses instead of forcing alignment.
module mem_stage_pipe #(
    parameter int DEPTH_LOG2 = 8,
    parameter int REG_W      = 5
) (
    input logic              clk,
    input logic              reset,
    mem_stage_pipe_if.slave  bus
);
    logic                  ex_valid, ex_mr, ex_mw, ex_uns, ex_rw;
    logic [31:0]           ex_addr, ex_sdata;
    logic [1:0]            ex_size;
    logic [REG_W-1:0]      ex_rd;
    logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rword, wd, ld;
    logic [7:0]            lb;
    logic [15:0]           hw;
    logic [3:0]            be;
    logic                  is_b, is_h, is_ld, mis, we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_addr  <= '0;
            ex_sdata <= '0;
            ex_mr    <= 1'b0;
            ex_mw    <= 1'b0;
            ex_size  <= '0;
            ex_uns   <= 1'b0;
            ex_rd    <= '0;
            ex_rw    <= 1'b0;
        end else if (bus.flush) begin
            ex_valid <= 1'b0;
        end else if (!bus.stall) begin
            ex_valid <= bus.in_valid;
            ex_addr  <= bus.alu_result;
            ex_sdata <= bus.store_data;
            ex_mr    <= bus.mem_read;
            ex_mw    <= bus.mem_write;
            ex_size  <= bus.mem_size;
            ex_uns   <= bus.mem_unsigned;
            ex_rd    <= bus.rd_in;
            ex_rw    <= bus.reg_write_in;
        end
    end

    always_comb begin
        idx   = ex_addr[DEPTH_LOG2+1:2];
        rword = mem[idx];
        is_b  = ex_size == 2'b00;
        is_h  = ex_size == 2'b01;
        is_ld = ex_mr & !ex_mw;
`ifdef MEM_ALIGN_CHECK_EN
        mis   = ex_valid & (ex_mr | ex_mw) &
                ((is_h & ex_addr[0]) | (!is_b & !is_h & (ex_addr[1:0] != 2'b00)));
`else
        mis   = 1'b0;
`endif
        // Without the alignment check, address bits below the access size are simply ignored.
        be    = is_b ? 4'b0001 << ex_addr[1:0] : is_h ? (ex_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd    = is_b ? {4{ex_sdata[7:0]}} : is_h ? {2{ex_sdata[15:0]}} : ex_sdata;
        we    = ex_valid & ex_mw & !bus.stall & !mis;
        lb    = rword[{ex_addr[1:0], 3'b000} +: 8];
        hw    = ex_addr[1] ? rword[31:16] : rword[15:0];
        ld    = is_b ? {{24{!ex_uns & lb[7]}}, lb} : is_h ? {{16{!ex_uns & hw[15]}}, hw} : rword;
    end

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid     <= 1'b0;
            bus.wb_data       <= '0;
            bus.rd_out        <= '0;
            bus.reg_write_out <= 1'b0;
            bus.misalign      <= 1'b0;
            bus.store_done    <= 1'b0;
        end else if (!bus.stall) begin
            bus.out_valid     <= ex_valid;
            bus.wb_data       <= !ex_valid ? 32'h0 : (is_ld & !mis) ? ld : ex_addr;
            bus.rd_out        <= ex_valid ? ex_rd : '0;
            bus.reg_write_out <= ex_valid & ex_rw & !ex_mw & !mis;
            bus.misalign      <= mis;
            bus.store_done    <= ex_valid & ex_mw & !mis;
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed checks of the memory stage against hand-computed results.
module tb_mem_stage_pipe;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_stage_pipe_if #(.REG_W(5)) bus ();
    mem_stage_pipe #(.DEPTH_LOG2(8), .REG_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd, input logic mr,
                         input logic mw, input logic [1:0] sz, input logic u, input logic [4:0] rd,
                         input logic rw);
        bus.in_valid     = v;
        bus.alu_result   = a;
        bus.store_data   = sd;
        bus.mem_read     = mr;
        bus.mem_write    = mw;
        bus.mem_size     = sz;
        bus.mem_unsigned = u;
        bus.rd_in        = rd;
        bus.reg_write_in = rw;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] sd, input logic [1:0] sz);
        drive(1'b1, a, sd, 1'b0, 1'b1, sz, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic ldm(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [4:0] rd);
        drive(1'b1, a, 32'h0, 1'b1, 1'b0, sz, u, rd, 1'b1);
    endtask

    task automatic bub;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic alu(input logic [31:0] a, input logic [4:0] rd);
        drive(1'b1, a, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, rd, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bub();
        tick();
        tick();
        reset = 1'b0;
        chk("reset out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("reset wb_data", bus.wb_data, 32'h0);
        chk("reset rd_out", {27'b0, bus.rd_out}, 32'h0);
        chk("reset reg_write", {31'b0, bus.reg_write_out}, 32'h0);
        chk("reset misalign", {31'b0, bus.misalign}, 32'h0);
        chk("reset store_done", {31'b0, bus.store_done}, 32'h0);
        // Mid-run asynchronous reset
        alu(32'h0000BEEF, 5'd2);
        tick();
        bub();
        tick();
        chk("pre-reset wb", bus.wb_data, 32'h0000BEEF);
        #2 reset = 1'b1;
        #1;
        chk("async reset out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("async reset wb", bus.wb_data, 32'h0);
        tick();
        reset = 1'b0;
        // Test 1: word store then word load
        st(32'h10, 32'hDEADBEEF, 2'b10);
        tick();
        ldm(32'h10, 2'b10, 1'b0, 5'd3);
        tick();
        chk("t1 store_done", {31'b0, bus.store_done}, 32'h1);
        chk("t1 store reg_write", {31'b0, bus.reg_write_out}, 32'h0);
        chk("t1 store out_valid", {31'b0, bus.out_valid}, 32'h1);
        bub();
        tick();
        chk("t1 load wb", bus.wb_data, 32'hDEADBEEF);
        chk("t1 load reg_write", {31'b0, bus.reg_write_out}, 32'h1);
        chk("t1 load rd", {27'b0, bus.rd_out}, 32'h3);
        chk("t1 load store_done", {31'b0, bus.store_done}, 32'h0);
        // Test 2: byte store, signed/unsigned byte loads, word readback
        st(32'h20, 32'h11223344, 2'b10);
        tick();
        st(32'h21, 32'hFFFFFF80, 2'b00);
        tick();
        ldm(32'h21, 2'b00, 1'b0, 5'd4);
        tick();
        ldm(32'h21, 2'b00, 1'b1, 5'd4);
        tick();
        chk("t2 lb signed", bus.wb_data, 32'hFFFFFF80);
        ldm(32'h20, 2'b10, 1'b0, 5'd4);
        tick();
        chk("t2 lb unsigned", bus.wb_data, 32'h00000080);
        bub();
        tick();
        chk("t2 word lane1", bus.wb_data, 32'h11228044);
        // Test 3: half store, signed load, aliased store at 0x432
        st(32'h32, 32'h12348001, 2'b01);
        tick();
        ldm(32'h32, 2'b01, 1'b0, 5'd8);
        tick();
        st(32'h432, 32'h00007FFF, 2'b01);
        tick();
        chk("t3 lh signed", bus.wb_data, 32'hFFFF8001);
        ldm(32'h32, 2'b01, 1'b1, 5'd8);
        tick();
        chk("t3 alias store_done", {31'b0, bus.store_done}, 32'h1);
        bub();
        tick();
        chk("t3 alias lhu", bus.wb_data, 32'h00007FFF);
        // Test 4: stall holds outputs, no re-pulse, no capture
        st(32'h40, 32'hCAFEF00D, 2'b10);
        tick();
        ldm(32'h40, 2'b10, 1'b0, 5'd5);
        tick();
        chk("t4 store_done", {31'b0, bus.store_done}, 32'h1);
        bus.stall = 1'b1;
        st(32'h40, 32'h99999999, 2'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4 stall store_done held", {31'b0, bus.store_done}, 32'h1);
            chk("t4 stall out_valid held", {31'b0, bus.out_valid}, 32'h1);
            chk("t4 stall reg_write held", {31'b0, bus.reg_write_out}, 32'h0);
        end
        bus.stall = 1'b0;
        bub();
        tick();
        chk("t4 load after stall", bus.wb_data, 32'hCAFEF00D);
        chk("t4 no re-pulse", {31'b0, bus.store_done}, 32'h0);
        chk("t4 load rd", {27'b0, bus.rd_out}, 32'h5);
        tick();
        chk("t4 bubble out_valid", {31'b0, bus.out_valid}, 32'h0);
        // Flushed store must not reach memory
        bus.flush = 1'b1;
        st(32'h40, 32'h55555555, 2'b10);
        tick();
        bus.flush = 1'b0;
        ldm(32'h40, 2'b10, 1'b0, 5'd5);
        tick();
        chk("t4 flush out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("t4 flush store_done", {31'b0, bus.store_done}, 32'h0);
        chk("t4 flush wb", bus.wb_data, 32'h0);
        bub();
        tick();
        chk("t4 flush mem kept", bus.wb_data, 32'hCAFEF00D);
        // Test 5: misaligned word store
        st(32'h13, 32'hA5A5A5A5, 2'b10);
        tick();
        ldm(32'h10, 2'b10, 1'b0, 5'd6);
        tick();
        chk("t5 reg_write", {31'b0, bus.reg_write_out}, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("t5 misalign", {31'b0, bus.misalign}, 32'h1);
        chk("t5 store_done", {31'b0, bus.store_done}, 32'h0);
        chk("t5 wb", bus.wb_data, 32'h13);
`else
        chk("t5 misalign", {31'b0, bus.misalign}, 32'h0);
        chk("t5 store_done", {31'b0, bus.store_done}, 32'h1);
`endif
        bub();
        tick();
        chk("t5 misalign cleared", {31'b0, bus.misalign}, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("t5 mem", bus.wb_data, 32'hDEADBEEF);
`else
        chk("t5 mem", bus.wb_data, 32'hA5A5A5A5);
`endif
        // Test 6: ALU pass-through then bubble
        alu(32'h12345678, 5'd7);
        tick();
        bub();
        tick();
        chk("t6 wb", bus.wb_data, 32'h12345678);
        chk("t6 rd", {27'b0, bus.rd_out}, 32'h7);
        chk("t6 out_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("t6 reg_write", {31'b0, bus.reg_write_out}, 32'h1);
        tick();
        chk("t6 bubble out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("t6 bubble wb", bus.wb_data, 32'h0);
        chk("t6 bubble reg_write", {31'b0, bus.reg_write_out}, 32'h0);
        // mem_read and mem_write together behave as a store
        drive(1'b1, 32'h50, 32'h00000077, 1'b1, 1'b1, 2'b10, 1'b0, 5'd9, 1'b1);
        tick();
        ldm(32'h50, 2'b10, 1'b0, 5'd9);
        tick();
        chk("rw both reg_write", {31'b0, bus.reg_write_out}, 32'h0);
        chk("rw both store_done", {31'b0, bus.store_done}, 32'h1);
        bub();
        tick();
        chk("rw both mem", bus.wb_data, 32'h00000077);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
